// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl_pkg
//  Purpose  : Shared state encodings and sizing helper for the bit-serial
//             add/subtract controller.
//  Revision : 1.0  initial release
// ============================================================================
package serial_add_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bit counter width: enough to count 0..w-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder_1b.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_1b
//  Purpose  : Single-bit combinational full adder; the only arithmetic
//             element of the serial add/subtract datapath.
//  Revision : 1.0  initial release
// ============================================================================
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Purpose  : Adds or subtracts two WIDTH-bit operands one bit per cycle,
//             LSB first, through a single 1-bit full adder. Result and
//             carry are held from the done pulse until the next result.
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_cout;

  full_adder_1b u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Result register after this cycle's bit enters from the MSB side.
  // A one-bit operand has nothing to shift, so the adder bit is the result.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_s;
    end else begin : g_res_wn
      assign res_next = {fa_s, res_sr[WIDTH-1:1]};
    end
  endgenerate

  // The bottom result bit falls off the end of the shift and is never read.
  logic unused_res_lsb;
  assign unused_res_lsb = res_sr[0];

  // Status outputs decode directly from the registered state.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Controller: operand latch, serial iteration, and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry.
            a_sr   <= a;
            b_sr   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            res_sr <= '0;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= fa_cout;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Purpose  : Self-checking bench for serial_add_ctrl (WIDTH = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic; carry out of an add is overflow,
  // carry out of a subtract means no borrow (a >= b).
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic s);
    int ux, uy, r;
    logic c;
    ux = int'(x);
    uy = int'(y);
    if (!s) begin
      r = ux + uy;
      c = (r >= (1 << WIDTH));
    end else begin
      r = ux - uy + (1 << WIDTH);
      c = (ux >= uy);
    end
    return {c, WIDTH'(r)};
  endfunction

  // One complete operation; poke_at >= 0 raises start with a=1,b=1 on that
  // RUN cycle (0 = first RUN cycle) to show it is ignored.
  task automatic do_op(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                       input logic sub_i, input int poke_at);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    int n, busy_cnt, changes;
    exp       = model(a_i, b_i, sub_i);
    held_sum  = sum;
    held_cout = cout;
    start = 1'b1; a = a_i; b = b_i; sub = sub_i;
    step();
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
    n = 0; busy_cnt = 0; changes = 0;
    while (!done && n < WIDTH + 4) begin
      if (busy) busy_cnt++;
      if (sum !== held_sum || cout !== held_cout) changes++;
      if (n == poke_at) begin
        start = 1'b1; a = 1; b = 1; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    check("latency", n, WIDTH);
    check("busy_cycles", busy_cnt, WIDTH);
    check("held_during_run", changes, 0);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("sum", sum, exp[WIDTH-1:0]);
    check("cout", cout, exp[WIDTH]);
    step();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int n, pulses;
    logic [WIDTH-1:0] ra, rb;
    logic             rs;

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) step();
    reset = 1'b0;

    // Idle after reset: everything quiet and cleared.
    for (int i = 0; i < 5; i++) begin
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_sum", sum, 0);
      check("idle_cout", cout, 0);
      step();
    end

    // Directed add/sub cases.
    do_op(8'd3,   8'd5,   1'b0, -1);
    do_op(8'd200, 8'd100, 1'b0, -1);
    do_op(8'd5,   8'd3,   1'b1, -1);
    do_op(8'd3,   8'd5,   1'b1, -1);
    do_op(8'd255, 8'd1,   1'b0, -1);
    do_op(8'd77,  8'd77,  1'b1, -1);
    do_op(8'd0,   8'd255, 1'b1, -1);

    // Start during RUN is ignored; no second done follows.
    do_op(8'd3, 8'd5, 1'b0, 2);
    pulses = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      if (done) pulses++;
      step();
    end
    check("no_extra_done", pulses, 0);
    check("sum_after_poke", sum, 8);

    // Reset on RUN cycle 4 discards the operation.
    start = 1'b1; a = 8'd50; b = 8'd60; sub = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    pulses = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      if (done) pulses++;
      step();
    end
    check("rst_no_done", pulses, 0);
    do_op(8'd50, 8'd60, 1'b0, -1);

    // Back-to-back: start held, new operands presented on the DONE cycle.
    start = 1'b1; a = 8'd10; b = 8'd20; sub = 1'b0;
    step();
    n = 0;
    while (!done && n < WIDTH + 4) begin
      step();
      n++;
    end
    check("b2b_latency1", n, WIDTH);
    check("b2b_sum1", sum, 30);
    a = 8'd7; b = 8'd9;
    step();
    start = 1'b0;
    check("b2b_no_idle", busy, 1);
    n = 1;
    while (!done && n < WIDTH + 5) begin
      step();
      n++;
    end
    check("b2b_period", n, WIDTH + 1);
    check("b2b_sum2", sum, 16);
    check("b2b_cout2", cout, 0);
    step();

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Multi-cycle controller that sequences a single 1-bit full-adder datapath to add or subtract two WIDTH-bit operands, one bit per cycle, LSB first. It latches operands on a start handshake, iterates WIDTH cycles with a registered carry, and presents a held result with a one-cycle done pulse. It is used wherever a narrow, area-minimal adder must serve wide operands.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result becomes valid
sum  output  WIDTH  result; held stable from done until next accepted start
cout  output  1  final carry out (sub: 1 = no borrow, i.e. a >= b unsigned)

Behaviour:
- One clock, clk; reset is synchronous and active-high; no asynchronous paths.
- Reset (including mid-operation): state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, bit counter=0, operand shift registers=0. Any in-flight operation is discarded without a done pulse.
- States: IDLE, RUN, DONE. Encoding is localparam constants from the shared package.
- IDLE: start=1 -> latch a into A-shift reg, (sub ? ~b : b) into B-shift reg, carry <= sub, counter <= 0, clear result shift reg, go RUN. start=0 -> stay.
- RUN: busy=1. Each cycle the full adder takes A[0], B[0], carry; result bit shifts into result reg MSB side (right shift); A and B shift right; carry <= adder cout; counter++. When counter==WIDTH-1 on this edge -> go DONE, sum <= completed result, cout <= final carry.
- DONE: done=1 for exactly one cycle, busy=0. start=1 -> accept new op exactly as from IDLE (back-to-back allowed), else -> IDLE.
- Latency: start sampled at edge k -> done high in cycle after edge k+WIDTH; busy high for exactly WIDTH cycles.
- start while RUN: ignored, no effect on operands or result.
- sum/cout change only on the RUN->DONE edge or reset; stable otherwise, including during the next RUN.
- Arithmetic is modulo 2^WIDTH; sub implemented as a + ~b + 1.
- WIDTH=1: RUN lasts one cycle; counter width is max(1, clog2(WIDTH)).
- No combinational path from inputs to outputs; all outputs registered or decoded from state.

Decomposition:
- Shared package (header of `define/localparam): state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
- One sub-module: full_adder_1b (inputs a, b, cin; outputs s, cout), purely combinational, instantiated once inside serial_add_ctrl.
- Controller keeps FSM, counter, shift registers and carry flop in the top module.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, sum=0, cout=0 throughout.
- WIDTH=8, start with a=3, b=5, sub=0 -> busy high 8 cycles, done pulse 8 cycles after start edge, sum=8, cout=0. Then a=200, b=100 -> sum=44, cout=1.
- sub=1, a=5, b=3 -> sum=2, cout=1; sub=1, a=3, b=5 -> sum=254, cout=0.
- Pulse start again with a=1, b=1 at cycle 3 of RUN of a=3+5 op -> ignored; result sum=8, and only one done pulse.
- Assert reset at cycle 4 of RUN -> next cycle state IDLE, busy=0, no done pulse, sum=0; a fresh start then yields the correct result.
- Hold start=1 continuously with a=10, b=20 then a=7, b=9 on the DONE cycle -> done pulses every 9 cycles, sums 30 then 16, no IDLE cycle between.
